// File: rtl/mem_data_ctrl.sv
// ---------------------------------------------------------------------------
// mem_data_ctrl -- MEM-stage load/store sequencer.
//
// Splits one 1/2/4-byte load or store into BUS_W-wide beats on a synchronous
// data memory with one cycle of read latency. The access cycle count goes to
// the stall controller in the request cycle. While the pipeline is stalled
// the beats run, and the assembled, extended load data is returned.
//
// Optional build macro: MEM_MISALIGN_CHECK_EN
//   defined   : misaligned requests are dropped and o_misalign_r pulses
//   undefined : misaligned addresses are aligned down; o_misalign_r is 0
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_req .. i_wdata    request: strobe, store flag, size, unsigned, addr, data
//   i_branch_met        pipeline flush
//   o_mem_data_access   access cycle count in the accept cycle, else 0
//   o_busy              sequencer not idle
//   o_mem_*_r, i_mem_rdata   beat bus (read data one cycle after o_mem_re_r)
//   o_rdata_r, o_rdata_valid_r   extended load result and completion pulse
//   o_misalign_r        dropped misaligned request pulse (macro builds only)
// ---------------------------------------------------------------------------
module mem_data_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BUS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_branch_met,
  output logic [3:0]        o_mem_data_access,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr_r,
  output logic [BUS_W-1:0]  o_mem_wdata_r,
  output logic              o_mem_we_r,
  output logic              o_mem_re_r,
  input  logic [BUS_W-1:0]  i_mem_rdata,
  output logic [DATA_W-1:0] o_rdata_r,
  output logic              o_rdata_valid_r,
  output logic              o_misalign_r
);

  localparam int BPB     = BUS_W / 8;       // bytes per beat
  localparam int BPB_LOG = $clog2(BPB);
  localparam int NLANES  = DATA_W / BUS_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BEAT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [1:0]        k_q;       // current beat index
  logic [1:0]        last_q;    // index of the final beat
  logic [1:0]        off_q;     // byte offset of the access inside a bus word
  logic [2:0]        bytes_q;
  logic              we_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;   // store data pre-shifted to its bus lanes
  logic [DATA_W-1:0] asm_q;     // load bytes assembled so far

  // Request decode
  logic [2:0]        req_bytes;
  logic [2:0]        req_beats;
  logic [ADDR_W-1:0] size_mask;
  logic [ADDR_W-1:0] aligned_addr;
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        lane_off;
  logic              accept;
  logic [DATA_W-1:0] store_shift;
  logic [BUS_W-1:0]  next_wdata;

  // Load result path
  logic [DATA_W-1:0] asm_full;
  logic [DATA_W-1:0] load_shift;
  logic [DATA_W-1:0] load_result;

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    req_bytes = 3'd4;
    case (i_size)
      2'd0:    req_bytes = 3'd1;
      2'd1:    req_bytes = 3'd2;
      default: req_bytes = 3'd4;   // size 3 behaves as a word
    endcase
    req_beats = req_bytes >> BPB_LOG;
    if (req_beats == 3'd0) req_beats = 3'd1;   // access narrower than the bus
  end

  assign size_mask    = ADDR_W'(req_bytes - 3'd1);
  assign aligned_addr = i_addr & ~size_mask;
  assign bus_addr     = aligned_addr & ~ADDR_W'(BPB - 1);
  assign lane_off     = aligned_addr[1:0] & 2'(BPB - 1);
  assign store_shift  = i_wdata << {lane_off, 3'b000};

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |(i_addr & size_mask);
  assign accept = !rst && i_req && (state_q == S_IDLE) && !i_branch_met && !misaligned;
`else
  assign accept = !rst && i_req && (state_q == S_IDLE) && !i_branch_met;
`endif

  // Loads need one extra cycle to capture the last beat's read data.
  assign o_mem_data_access = accept ? ({1'b0, req_beats} + {3'b000, ~i_we}) : 4'd0;
  assign o_busy            = (state_q != S_IDLE);

  // Store data for the beat after the current one.
  assign next_wdata = BUS_W'(wdata_q >> (BUS_W * (int'(k_q) + 1)));

  // Final assembly: the last beat's data is merged straight from the bus in
  // the capture cycle, then moved down to bit 0 and extended.
  always_comb begin
    asm_full = asm_q;
    for (int l = 0; l < NLANES; l++) begin
      if (l == int'(k_q)) asm_full[l*BUS_W +: BUS_W] = i_mem_rdata;
    end
    load_shift  = asm_full >> {off_q, 3'b000};
    load_result = load_shift;
    case (bytes_q)
      3'd1:    load_result = {{(DATA_W-8){~uns_q & load_shift[7]}}, load_shift[7:0]};
      3'd2:    load_result = {{(DATA_W-16){~uns_q & load_shift[15]}}, load_shift[15:0]};
      default: load_result = load_shift;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_BEAT;
      S_BEAT: begin
        // A flush aborts loads only; a started store always finishes so
        // memory never sees a partial write.
        if (!we_q && i_branch_met)  state_d = S_IDLE;
        else if (k_q == last_q)     state_d = we_q ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the control state so
  // every registered output reads 0 from the moment reset is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q             <= '0;
      last_q          <= '0;
      off_q           <= '0;
      bytes_q         <= '0;
      we_q            <= 1'b0;
      uns_q           <= 1'b0;
      wdata_q         <= '0;
      asm_q           <= '0;
      o_mem_addr_r    <= '0;
      o_mem_wdata_r   <= '0;
      o_mem_we_r      <= 1'b0;
      o_mem_re_r      <= 1'b0;
      o_rdata_r       <= '0;
      o_rdata_valid_r <= 1'b0;
    end else begin
      o_rdata_valid_r <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            k_q           <= 2'd0;
            last_q        <= 2'(req_beats - 3'd1);
            off_q         <= lane_off;
            bytes_q       <= req_bytes;
            we_q          <= i_we;
            uns_q         <= i_unsigned;
            wdata_q       <= store_shift;
            o_mem_addr_r  <= bus_addr;
            o_mem_wdata_r <= store_shift[BUS_W-1:0];
            o_mem_we_r    <= i_we;
            o_mem_re_r    <= ~i_we;
          end
        end
        S_BEAT: begin
          // Read data of the previous beat arrives during this beat.
          if (!we_q) begin
            for (int l = 0; l < NLANES; l++) begin
              if (l == int'(k_q) - 1) asm_q[l*BUS_W +: BUS_W] <= i_mem_rdata;
            end
          end
          if ((!we_q && i_branch_met) || (k_q == last_q)) begin
            o_mem_we_r <= 1'b0;
            o_mem_re_r <= 1'b0;
          end else begin
            k_q           <= k_q + 2'd1;
            o_mem_addr_r  <= o_mem_addr_r + ADDR_W'(BPB);
            o_mem_wdata_r <= next_wdata;
          end
        end
        S_CAPTURE: begin
          if (!i_branch_met) begin
            o_rdata_r       <= load_result;
            o_rdata_valid_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_misalign_r <= 1'b0;
    else     o_misalign_r <= i_req && (state_q == S_IDLE) && !i_branch_met && misaligned;
  end
`else
  assign o_misalign_r = 1'b0;
`endif

endmodule

// File: tb/tb_mem_data_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_data_ctrl -- self-checking bench for mem_data_ctrl (BUS_W = 8).
// A byte-array bus memory answers the DUT; a reference byte array tracks what
// memory should hold and predicts counts, bus traces and load results.
// ---------------------------------------------------------------------------
module tb_mem_data_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [1:0]  i_size = 2'd0;
  logic        i_unsigned = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_branch_met = 1'b0;
  logic [3:0]  o_mem_data_access;
  logic        o_busy;
  logic [31:0] o_mem_addr_r;
  logic [7:0]  o_mem_wdata_r;
  logic        o_mem_we_r;
  logic        o_mem_re_r;
  logic [7:0]  i_mem_rdata = 8'h00;
  logic [31:0] o_rdata_r;
  logic        o_rdata_valid_r;
  logic        o_misalign_r;

  always #5 clk = ~clk;

  mem_data_ctrl #(.ADDR_W(32), .DATA_W(32), .BUS_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_req             (i_req),
    .i_we              (i_we),
    .i_size            (i_size),
    .i_unsigned        (i_unsigned),
    .i_addr            (i_addr),
    .i_wdata           (i_wdata),
    .i_branch_met      (i_branch_met),
    .o_mem_data_access (o_mem_data_access),
    .o_busy            (o_busy),
    .o_mem_addr_r      (o_mem_addr_r),
    .o_mem_wdata_r     (o_mem_wdata_r),
    .o_mem_we_r        (o_mem_we_r),
    .o_mem_re_r        (o_mem_re_r),
    .i_mem_rdata       (i_mem_rdata),
    .o_rdata_r         (o_rdata_r),
    .o_rdata_valid_r   (o_rdata_valid_r),
    .o_misalign_r      (o_misalign_r)
  );

  logic [7:0] init_mem [0:1023];
  logic [7:0] ref_mem  [0:1023];
  logic [7:0] bus_mem  [0:1023];
  logic       preload = 1'b0;

  // Synchronous memory with one cycle of read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) bus_mem[i] <= init_mem[i];
    end else begin
      if (o_mem_we_r) bus_mem[o_mem_addr_r[9:0]] <= o_mem_wdata_r;
      if (o_mem_re_r) i_mem_rdata <= bus_mem[o_mem_addr_r[9:0]];
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Little-endian load of n bytes from the reference memory, then extended.
  function automatic logic [31:0] model_load(input int n, input logic [31:0] a, input bit uns);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v = v + (32'(ref_mem[10'(a + 32'(j))]) << (8 * j));
    if (!uns && n == 1 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
    if (!uns && n == 2 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  // One request from an idle sequencer. flush_at is the busy-cycle index on
  // which i_branch_met is raised (-1: never); poke_busy raises i_req on busy
  // cycle 1.
  task automatic run_req(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int flush_at, input bit poke_busy);
    int          n, exp_cnt, exp_busy, exp_strobes, busy_cycles, nstrobe, cyc;
    bit          drop, aborted, exp_valid;
    logic [31:0] eff, exp_val;
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    eff  = addr - (addr % 32'(n));
    drop = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    drop = (addr % 32'(n)) != 0;
`endif
    aborted     = !we && !drop && flush_at >= 0 && flush_at <= n;
    exp_valid   = !we && !drop && !aborted;
    exp_cnt     = drop ? 0 : n + (we ? 0 : 1);
    exp_busy    = aborted ? flush_at + 1 : exp_cnt;
    exp_strobes = drop ? 0 : (aborted && flush_at + 1 < n) ? flush_at + 1 : n;
    exp_val     = model_load(n, eff, uns);
    if (we && !drop)
      for (int j = 0; j < n; j++) ref_mem[10'(eff + 32'(j))] = 8'(wd >> (8 * j));

    i_we = we; i_size = size; i_unsigned = uns; i_addr = addr; i_wdata = wd;
    i_req = 1'b1;
    #1 check("count", 32'(o_mem_data_access), 32'(exp_cnt));
    @(negedge clk);
    i_req = 1'b0;
    check("misalign", 32'(o_misalign_r), 32'(drop));
    busy_cycles = 0;
    nstrobe     = 0;
    for (cyc = 0; cyc < 20 && o_busy; cyc++) begin
      busy_cycles++;
      check("valid_while_busy", 32'(o_rdata_valid_r), 32'd0);
      if (o_mem_re_r || o_mem_we_r) begin
        check("bus_addr", o_mem_addr_r, eff + 32'(nstrobe));
        check("bus_we", 32'(o_mem_we_r), 32'(we));
        if (we) check("bus_wdata", 32'(o_mem_wdata_r), 32'(8'(wd >> (8 * nstrobe))));
        nstrobe++;
      end
      i_branch_met = (cyc == flush_at);
      i_req        = poke_busy && (cyc == 1);
      if (i_req) #1 check("count_while_busy", 32'(o_mem_data_access), 32'd0);
      @(negedge clk);
    end
    i_req = 1'b0;
    i_branch_met = 1'b0;
    check("idle_within_budget", 32'(o_busy), 32'd0);
    check("strobe_count", 32'(nstrobe), 32'(exp_strobes));
    check("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
    check("valid_pulse", 32'(o_rdata_valid_r), 32'(exp_valid));
    if (exp_valid) last_rdata = exp_val;
    check("rdata", o_rdata_r, last_rdata);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) init_mem[i] = 8'($urandom);
    init_mem[10'h100] = 8'h11;
    init_mem[10'h101] = 8'h22;
    init_mem[10'h102] = 8'h33;
    init_mem[10'h103] = 8'h44;
    init_mem[10'h007] = 8'h80;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_mem[i];

    // Reset, with the memory preloaded meanwhile.
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_re", 32'(o_mem_re_r), 32'd0);
    check("rst_we", 32'(o_mem_we_r), 32'd0);
    check("rst_addr", o_mem_addr_r, 32'd0);
    check("rst_rdata", o_rdata_r, 32'd0);
    check("rst_valid", 32'(o_rdata_valid_r), 32'd0);
    check("rst_count", 32'(o_mem_data_access), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word load of 11 22 33 44.
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, -1, 1'b0);
    check("word_load_value", o_rdata_r, 32'h4433_2211);

    // Signed and unsigned byte loads of 0x80.
    run_req(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, -1, 1'b0);
    check("byte_signed", o_rdata_r, 32'hFFFF_FF80);
    run_req(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, -1, 1'b0);
    check("byte_unsigned", o_rdata_r, 32'h0000_0080);

    // Half store, read back.
    run_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h1234_BEEF, -1, 1'b0);
    run_req(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, -1, 1'b0);
    check("half_readback", o_rdata_r, 32'h0000_BEEF);

    // Word load flushed on its 2nd beat, then an immediate new request.
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1, 1'b0);
    run_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, -1, 1'b0);

    // Word store flushed on beat 1 with a request poked while busy.
    run_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, 1, 1'b1);
    run_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, -1, 1'b0);
    check("store_survives_flush", o_rdata_r, 32'hCAFE_F00D);

    // Misaligned word load (dropped or aligned down, depending on build).
    run_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, -1, 1'b0);
    // Size 3 acts as a word.
    run_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, -1, 1'b0);

    // Flush in the accept cycle drops the request.
    i_we = 1'b0; i_size = 2'd2; i_addr = 32'h100;
    i_req = 1'b1; i_branch_met = 1'b1;
    #1 check("flush_accept_count", 32'(o_mem_data_access), 32'd0);
    @(negedge clk);
    i_req = 1'b0; i_branch_met = 1'b0;
    check("flush_accept_busy", 32'(o_busy), 32'd0);
    check("flush_accept_re", 32'(o_mem_re_r), 32'd0);

    // Randomized requests.
    for (int r = 0; r < 60; r++) begin
      run_req(1'($urandom), 2'($urandom), 1'($urandom),
              32'($urandom_range(0, 1000)), $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1,
              1'($urandom));
    end

    // Reset in the middle of a word load.
    i_we = 1'b0; i_size = 2'd2; i_addr = 32'h80; i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_re", 32'(o_mem_re_r), 32'd0);
    check("midrst_addr", o_mem_addr_r, 32'd0);
    check("midrst_wdata", 32'(o_mem_wdata_r), 32'd0);
    check("midrst_rdata", o_rdata_r, 32'd0);
    check("midrst_valid", 32'(o_rdata_valid_r), 32'd0);
    last_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, -1, 1'b0);
    check("after_reset_load", o_rdata_r, 32'h0000_0022);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_data_ctrl.md
Name: mem_data_ctrl

Overview:
MEM-stage load/store sequencer for the pipelined core. It takes one load/store request per instruction and splits it into narrow beats on a fixed-latency synchronous data memory bus. In the request cycle it reports the total access cycle count to the stall controller. It then runs the beats while the pipeline is stalled and returns assembled, extended load data.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, core data width (fixed at 32)
BUS_W, 8, memory bus width in bits; legal values 8, 16, 32

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_req  in  1  load/store request, valid for one cycle
i_we  in  1  1 = store, 0 = load
i_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
i_unsigned  in  1  zero-extend load (else sign-extend)
i_addr  in  ADDR_W  byte address
i_wdata  in  DATA_W  store data, right-aligned
i_branch_met  in  1  pipeline flush
o_mem_data_access  out  4  cycle count for the stall controller (combinational)
o_busy  out  1  sequencer not idle
o_mem_addr_r  out  ADDR_W  bus address, beat-aligned
o_mem_wdata_r  out  BUS_W  bus write data
o_mem_we_r  out  1  bus write strobe
o_mem_re_r  out  1  bus read strobe
i_mem_rdata  in  BUS_W  read data, valid the cycle after o_mem_re_r
o_rdata_r  out  DATA_W  extended load result
o_rdata_valid_r  out  1  one-cycle pulse, load complete
o_misalign_r  out  1  one-cycle pulse, dropped misaligned request (macro only)

Behaviour:
- Reset (async, rst=1): state IDLE; all _r outputs 0; o_busy 0.
- Accept condition: i_req & IDLE & !i_branch_met & request aligned (alignment checked only with the macro).
- bytes = 1/2/4 for byte/half/word. BPB = BUS_W/8. beats = max(1, bytes/BPB).
- o_mem_data_access = beats + (load ? 1 : 0) in the accept cycle; 0 in every other cycle. Maximum value 5 (word load, BUS_W=8).
- States:
  - IDLE: on accept, latch address, data, size, sign and we; go to BEAT with beat index k=0.
  - BEAT: drive o_mem_addr_r = base + k*BPB and the strobe for one cycle per beat, little-endian byte order. Store data for beat k = i_wdata[k*BUS_W +: BUS_W]. After the last beat: a store goes to IDLE; a load goes to CAPTURE.
  - CAPTURE: take the final read byte; o_rdata_valid_r=1 for one cycle; go to IDLE.
- Load data: i_mem_rdata for beat k is written into byte lane k one cycle after its strobe, so the capture pipeline overlaps the next beat. The result is zero- or sign-extended from bytes*8 bits per i_unsigned.
- Total cycles from accept to return to IDLE equal o_mem_data_access exactly.
- o_busy = state != IDLE. i_req while busy is ignored and reports count 0.
- i_branch_met in the accept cycle: request dropped, count 0.
- i_branch_met during a load (BEAT/CAPTURE): abort to IDLE next cycle; strobes drop; no o_rdata_valid_r.
- i_branch_met during a store: ignored; the store runs to completion so no torn writes reach memory.
- Strobes are 0 in IDLE; o_mem_addr_r and o_mem_wdata_r hold their last values.
- o_rdata_r holds its value until the next completed load.

Optional Feature:
MEM_MISALIGN_CHECK_EN
- Defined: a request with i_addr mod bytes != 0 is not accepted. o_misalign_r pulses one cycle after i_req; count 0; no bus activity.
- Undefined: the low address bits below the access size are forced to 0 (access is aligned down); o_misalign_r is tied 0.

Test Plan:
- BUS_W=8, word load at 0x100, memory bytes 11 22 33 44: count=5 in the accept cycle; re at 0x100..0x103 on 4 consecutive cycles; o_rdata_r=0x44332211 with the valid pulse on cycle 5; IDLE after.
- Signed byte load of 0x80 at 0x7 -> o_rdata_r=0xFFFFFF80; same with i_unsigned=1 -> 0x00000080; count=2.
- Half store of 0xBEEF at 0x20 -> count=2; we at 0x20 with 0xEF, then 0x21 with 0xBE; no valid pulse.
- Word load, i_branch_met on the 2nd beat -> strobes stop next cycle; no valid pulse; a new request accepted right after gets its correct count.
- Word store, i_branch_met on beat 1 -> all 4 writes still occur; i_req while busy gives count 0 and is ignored.
- With MEM_MISALIGN_CHECK_EN: word load at 0x102 -> o_misalign_r pulse, count 0, no strobes. Without the macro: same request accesses 0x100..0x103. Assert rst mid-access -> all outputs 0 immediately.
